// File: rtl/msg_tx_scheduler.sv
// Arbitrates the single UART transmitter between the RDM/RPM/SLM message generators.
// A source keeps the grant for its whole message, and losers are aged so they cannot starve.
module msg_tx_scheduler #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int AGE_LIMIT      = 4
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  byte_valid,
    input  logic [23:0] byte_data,
    input  logic [2:0]  byte_last,
    output logic [2:0]  byte_ready,
    output logic [2:0]  grant,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        msg_done,
    output logic        timeout_err,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_TX, GAP} state_t;

    state_t          state, state_nx;
    logic [2:0][3:0] age_q, age_nx;
    logic [2:0]      starved, pick, winner;
    logic [TW-1:0]   tcnt;
    logic [GW-1:0]   gcnt;
    logic            last_q;
    logic            xfer, t_expired, g_expired;
    logic [7:0]      byte_sel;

    // Aged sources win first; within a class the lowest index wins.
    always_comb begin
        starved = '0;
        for (int i = 0; i < 3; i++)
            starved[i] = req[i] && (AGE_LIMIT != 0) && (age_q[i] >= 4'(AGE_LIMIT));
        pick   = (starved != '0) ? starved : req;
        winner = pick & 3'(~pick + 3'd1);
        age_nx = '0;
        for (int i = 0; i < 3; i++) begin
            if (winner[i])  age_nx[i] = 4'd0;
            else if (req[i]) age_nx[i] = (age_q[i] == 4'd15) ? 4'd15 : age_q[i] + 4'd1;
            else             age_nx[i] = 4'd0;
        end
    end

    always_comb begin
        byte_sel = 8'h00;
        for (int i = 0; i < 3; i++)
            if (grant[i]) byte_sel = byte_data[8*i +: 8];
    end

    assign xfer      = |(byte_valid & grant);
    assign t_expired = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign g_expired = (gcnt == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk_50M) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req != 3'b000) state_nx = FETCH;
            FETCH:   if (xfer) state_nx = SEND;
                     else if (t_expired) state_nx = GAP;
            SEND:    state_nx = WAIT_TX;
            WAIT_TX: if (tx_done) state_nx = last_q ? GAP : FETCH;
            GAP:     if (g_expired) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == FETCH) ? grant : 3'b000;
        tx_start   = (state == SEND);
        busy       = (state != IDLE);
    end

    // tx_data only moves on a byte transfer, so it is stable for the whole UART frame.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            grant       <= '0;
            tx_data     <= '0;
            last_q      <= 1'b0;
            msg_done    <= 1'b0;
            timeout_err <= 1'b0;
            age_q       <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
        end else begin
            msg_done    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (req != 3'b000) begin
                    grant <= winner;
                    age_q <= age_nx;
                    tcnt  <= '0;
                end
                FETCH: begin
                    if (xfer) begin
                        tx_data <= byte_sel;
                        last_q  <= |(byte_last & grant);
                    end else if (t_expired) begin
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        gcnt        <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WAIT_TX: if (tx_done) begin
                    if (last_q) begin
                        msg_done <= 1'b1;
                        grant    <= '0;
                        gcnt     <= '0;
                    end else begin
                        tcnt <= '0;
                    end
                end
                GAP: gcnt <= gcnt + GW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_tx_scheduler.sv
// Bench for msg_tx_scheduler: directed scenarios plus randomized messages, checked against
// an age-based arbitration model and expected per-byte handshake timing.
module tb_msg_tx_scheduler;
    localparam int GAP = 4;
    localparam int TMO = 100;
    localparam int AGL = 2;

    logic        clk_50M = 1'b0;
    logic        reset;
    logic [2:0]  req, byte_valid, byte_last, byte_ready, grant;
    logic [23:0] byte_data;
    logic [7:0]  tx_data;
    logic        tx_start, tx_done, msg_done, timeout_err, busy;

    // fixed-priority instance: everyone always requesting, UART always done
    logic [2:0]  fp_req, fp_valid, fp_last, fp_ready, fp_grant;
    logic [23:0] fp_data;
    logic [7:0]  fp_tx_data;
    logic        fp_tx_start, fp_tx_done, fp_msg_done, fp_tmo, fp_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int age [3];

    always #10 clk_50M = ~clk_50M;

    msg_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .AGE_LIMIT(AGL)) dut (
        .clk_50M(clk_50M), .reset(reset), .req(req), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
        .grant(grant), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .msg_done(msg_done), .timeout_err(timeout_err), .busy(busy));

    msg_tx_scheduler #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(TMO), .AGE_LIMIT(0)) dut_fp (
        .clk_50M(clk_50M), .reset(reset), .req(fp_req), .byte_valid(fp_valid),
        .byte_data(fp_data), .byte_last(fp_last), .byte_ready(fp_ready),
        .grant(fp_grant), .tx_data(fp_tx_data), .tx_start(fp_tx_start), .tx_done(fp_tx_done),
        .msg_done(fp_msg_done), .timeout_err(fp_tmo), .busy(fp_busy));

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: promote aged requesters, else lowest index; then re-age.
    task automatic model_arb(input logic [2:0] m, output logic [2:0] g);
        int w = -1;
        for (int j = 0; j < 3; j++)
            if (w < 0 && AGL > 0 && m[j] && age[j] >= AGL) w = j;
        for (int j = 0; j < 3; j++)
            if (w < 0 && m[j]) w = j;
        for (int j = 0; j < 3; j++)
            if (j == w)    age[j] = 0;
            else if (m[j]) age[j] = (age[j] >= 15) ? 15 : age[j] + 1;
            else           age[j] = 0;
        g = 3'b001 << w;
    endtask

    task automatic gap_check();
        req = 3'b000;
        for (int k = 0; k < GAP - 1; k++) begin
            chk("gap_busy", busy, 1'b1);
            chk("gap_grant", grant, 3'b000);
            chk("gap_ready", byte_ready, 3'b000);
            tx_done    = 1'($urandom_range(1));
            byte_valid = 3'($urandom);
            tick();
            chk("gap_msg_done", msg_done, 1'b0);
        end
        chk("gap_busy_last", busy, 1'b1);
        tick();
        tx_done = 1'b0; byte_valid = 3'b000;
        chk("idle_busy", busy, 1'b0);
        chk("idle_grant", grant, 3'b000);
    endtask

    // One granted message of n bytes; bytes==0 means random data, wfix<0 random UART time,
    // abort_byte=k returns while waiting for tx_done of byte k.
    task automatic do_msg(input logic [2:0] mask, input int n, input logic [23:0] bytes,
                          input int wfix, input int abort_byte, output logic [2:0] gobs);
        logic [2:0] g;
        logic [7:0] b;
        int gi, d, w;
        model_arb(mask, g);
        gi = g[0] ? 0 : (g[1] ? 1 : 2);
        req = mask; byte_valid = 3'b000; tx_done = 1'b0;
        tick();
        gobs = grant;
        req = 3'($urandom);
        chk("grant", grant, g);
        chk("busy", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            b = (bytes == 24'h0) ? 8'($urandom) : bytes[8*i +: 8];
            d = $urandom_range(3);
            for (int k = 0; k < d; k++) begin
                byte_valid = 3'($urandom) & ~g;
                byte_data  = $urandom;
                byte_last  = 3'($urandom);
                tx_done    = 1'($urandom_range(1));
                chk("ready_wait", byte_ready, g);
                tick();
                chk("no_start", tx_start, 1'b0);
            end
            tx_done    = 1'b0;
            byte_valid = (3'($urandom) & ~g) | g;
            byte_data  = $urandom;
            byte_data[8*gi +: 8] = b;
            byte_last  = 3'($urandom);
            byte_last[gi] = (i == n - 1);
            chk("ready_xfer", byte_ready, g);
            tick();
            byte_valid = 3'($urandom) & ~g;
            chk("tx_start", tx_start, 1'b1);
            chk("tx_data", tx_data, b);
            chk("ready_send", byte_ready, 3'b000);
            w = (wfix >= 0) ? wfix : $urandom_range(4);
            tick();
            chk("start_once", tx_start, 1'b0);
            for (int k = 0; k < w; k++) begin
                byte_valid = 3'($urandom);
                byte_data  = $urandom;
                tick();
                chk("tx_data_hold", tx_data, b);
                chk("wait_msg_done", msg_done, 1'b0);
            end
            if (abort_byte == i + 1) return;
            byte_valid = 3'b000;
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("msg_done", msg_done, (i == n - 1));
            chk("tx_data_after", tx_data, b);
            if (i == n - 1) begin
                chk("grant_released", grant, 3'b000);
                chk("busy_gap", busy, 1'b1);
            end
        end
        gap_check();
    endtask

    initial begin
        logic [2:0] gobs;
        logic [2:0] seq [6];
        int rdm_cnt;
        seq = '{3'b001, 3'b001, 3'b100, 3'b001, 3'b001, 3'b100};
        fp_req = 3'b111; fp_valid = 3'b111; fp_last = 3'b111; fp_data = 24'h33_22_11; fp_tx_done = 1'b1;
        req = 0; byte_valid = 0; byte_last = 0; byte_data = 0; tx_done = 0;
        for (int j = 0; j < 3; j++) age[j] = 0;

        reset = 1'b1;
        tick(); tick();
        chk("rst_grant", grant, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_ready", byte_ready, 3'b000);
        chk("rst_msg_done", msg_done, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        reset = 1'b0;
        tick();

        // ageing: RDM+SLM always requesting
        for (int i = 0; i < 6; i++) begin
            do_msg(3'b101, 1, 24'h0, -1, 0, gobs);
            chk("age_seq", gobs, seq[i]);
        end

        // three-byte RDM message, UART done 5 cycles after each start
        do_msg(3'b001, 3, 24'hA3_A2_A1, 4, 0, gobs);

        // RPM granted but never supplies a byte
        model_arb(3'b010, gobs);
        req = 3'b010; tick(); req = 3'b000;
        chk("tmo_grant", grant, gobs);
        for (int k = 0; k < TMO - 1; k++) begin
            byte_valid = 3'($urandom) & 3'b101;
            tx_done    = 1'($urandom_range(1));
            tick();
            chk("tmo_early", timeout_err, 1'b0);
            chk("tmo_no_start", tx_start, 1'b0);
        end
        tick();
        chk("tmo_pulse", timeout_err, 1'b1);
        chk("tmo_grant_rel", grant, 3'b000);
        chk("tmo_busy", busy, 1'b1);
        tick();
        chk("tmo_one_cycle", timeout_err, 1'b0);
        // one GAP cycle already consumed above
        for (int k = 0; k < GAP - 2; k++) begin
            req = 3'b111;
            chk("tmo_gap_busy", busy, 1'b1);
            tick();
        end
        req = 3'b000;
        tick();
        chk("tmo_idle", busy, 1'b0);

        // reset while waiting for tx_done of byte 2
        do_msg(3'b001, 3, 24'hC3_C2_C1, 2, 2, gobs);
        req = 3'b000; byte_valid = 3'b000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int j = 0; j < 3; j++) age[j] = 0;
        chk("mrst_grant", grant, 3'b000);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_tx_data", tx_data, 8'h00);
        chk("mrst_ready", byte_ready, 3'b000);
        chk("mrst_msg_done", msg_done, 1'b0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("mrst_late_done", msg_done, 1'b0);
        chk("mrst_still_idle", busy, 1'b0);
        tick();

        // randomized messages
        for (int t = 0; t < 40; t++)
            do_msg(3'($urandom_range(1, 7)), $urandom_range(1, 3), 24'h0, -1, 0, gobs);

        // fixed-priority instance never grants RPM or SLM
        rdm_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("fp_no_low", fp_grant & 3'b110, 3'b000);
            if (fp_grant == 3'b001) rdm_cnt++;
        end
        chk("fp_rdm_granted", (rdm_cnt > 0), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
